// File: rtl/mips_pkg.sv
// Shared MIPS encoder types: mnemonic enum, opcode constants and opcode lookup.
package mips_pkg;

    typedef enum logic [4:0] {
        RTYPE, JR, LW, SW, BEQ, BNE, ADDI, ORI, J, LH,
        LB, LBU, ANDI, JAL, LUI, XORI, BLEZ, SLTI, BGTZ
    } mnem_t;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    localparam logic [5:0] FUNCT_JR   = 6'b001000;

    function automatic logic [5:0] opcode_of(mnem_t m);
        case (m)
            LW:      return OP_LW;
            SW:      return OP_SW;
            BEQ:     return OP_BEQ;
            BNE:     return OP_BNE;
            ADDI:    return OP_ADDI;
            ORI:     return OP_ORI;
            J:       return OP_J;
            LH:      return OP_LH;
            LB:      return OP_LB;
            LBU:     return OP_LBU;
            ANDI:    return OP_ANDI;
            JAL:     return OP_JAL;
            LUI:     return OP_LUI;
            XORI:    return OP_XORI;
            BLEZ:    return OP_BLEZ;
            SLTI:    return OP_SLTI;
            BGTZ:    return OP_BGTZ;
            default: return OP_SPECIAL;
        endcase
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/output bundle of instr_encoder; slave is the encoder side, master the requester/consumer.
interface instr_encoder_if;
    import mips_pkg::*;

    logic        in_valid;
    logic        in_ready;
    mnem_t       mnem;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err;

    modport slave (
        input  in_valid, mnem, rs, rt, rd, shamt, funct, imm, target, out_ready,
        output in_ready, out_valid, out_instr, out_addr, err
    );

    modport master (
        output in_valid, mnem, rs, rt, rd, shamt, funct, imm, target, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, err
    );

endinterface

// File: rtl/instr_fifo.sv
// Synchronous FIFO with extra pointer bit for full/empty; reset and clear both flush it.
module instr_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;
    logic             w_flush;

    assign w_flush   = reset || clear;
    assign w_do_push = push && !full && !w_flush;
    assign w_do_pop  = pop && !empty && !w_flush;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// MIPS instruction encoder with output FIFO and byte-address counter.
// Compile option: MIPS_ENC_EXT_EN enables the extended mnemonic set.
module instr_encoder
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    instr_encoder_if.slave bus
);

    logic        w_legal;
    logic [31:0] w_instr;
    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_fifo_dout;
    logic [31:0] r_addr;
    logic        r_err;

    always_comb begin
        w_legal = 1'b0;
        case (bus.mnem)
`ifdef MIPS_ENC_EXT_EN
            RTYPE, JR, LW, SW, BEQ, BNE, ADDI, ORI, J, LH,
            LB, LBU, ANDI, JAL, LUI, XORI, BLEZ, SLTI, BGTZ: w_legal = 1'b1;
`else
            RTYPE, JR, LW, SW, BEQ, ADDI, ORI, J:           w_legal = 1'b1;
`endif
            default:                                        w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_instr = '0;
        case (bus.mnem)
            RTYPE:   w_instr = {OP_SPECIAL, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
            JR:      w_instr = {OP_SPECIAL, bus.rs, 15'b0, FUNCT_JR};
            J, JAL:  w_instr = {opcode_of(bus.mnem), bus.target};
            default: w_instr = {opcode_of(bus.mnem), bus.rs, bus.rt, bus.imm};
        endcase
    end

    assign w_accept = bus.in_valid && !w_full;
    assign w_push   = w_accept && w_legal;
    assign w_pop    = !w_empty && bus.out_ready;

    instr_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (w_push),
        .din   (w_instr),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_addr <= BASE_ADDR;
        end else if (w_pop) begin
            r_addr <= r_addr + 32'd4;
        end
    end

    // A discarded (cleared) request is not an illegal-request event.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && !w_legal;
        end
    end

    assign bus.in_ready  = !w_full;
    assign bus.out_valid = !w_empty;
    assign bus.out_instr = w_empty ? '0 : w_fifo_dout;
    assign bus.out_addr  = r_addr;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table, directed corner sequences, random traffic vs queue model.
module tb_instr_encoder;
    import mips_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] WBASE = 32'hFFFF_FFFC;
`ifdef MIPS_ENC_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    typedef struct {
        mnem_t       mnem;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
    } req_t;

    typedef struct {
        req_t        req;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset, clear, clear_w;
    always #5 clk = ~clk;

    instr_encoder_if bus ();
    instr_encoder_if wbus ();

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .clear(clear), .bus(bus)
    );
    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(WBASE)) dut_wrap (
        .clk(clk), .reset(reset), .clear(clear_w), .bus(wbus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] mq[$];
    logic [31:0] m_addr;
    logic        m_err;

    // Opcode per mnemonic, in enum declaration order.
    logic [5:0] op_tab [19] = '{6'b000000, 6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                6'b000101, 6'b001000, 6'b001101, 6'b000010, 6'b100001,
                                6'b100000, 6'b100100, 6'b001100, 6'b000011, 6'b001111,
                                6'b001110, 6'b000110, 6'b001010, 6'b000111};

    function automatic bit m_legal(mnem_t m);
        int code = int'(m);
        if (EXT) return code <= 18;
        return code inside {0, 1, 2, 3, 4, 6, 7, 8};
    endfunction

    function automatic logic [31:0] m_enc(req_t r);
        int code = int'(r.mnem);
        logic [31:0] w;
        if (code == 0)                   w = {6'd0, r.rs, r.rt, r.rd, r.shamt, r.funct};
        else if (code == 1)              w = {6'd0, r.rs, 15'd0, 6'd8};
        else if (code == 8 || code == 13) w = {op_tab[code], r.target};
        else                             w = {op_tab[code], r.rs, r.rt, r.imm};
        return w;
    endfunction

    function automatic req_t mk(mnem_t m, int rs, int rt, int rd, int sh, int fn,
                                int imm, int tgt);
        req_t r;
        r.mnem = m; r.rs = 5'(rs); r.rt = 5'(rt); r.rd = 5'(rd); r.shamt = 5'(sh);
        r.funct = 6'(fn); r.imm = 16'(imm); r.target = 26'(tgt);
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.mnem = mnem_t'(5'($urandom_range(0, 31)));
        r.rs = 5'($urandom); r.rt = 5'($urandom); r.rd = 5'($urandom);
        r.shamt = 5'($urandom); r.funct = 6'($urandom); r.imm = 16'($urandom);
        r.target = 26'($urandom);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input req_t r, input logic v);
        bus.in_valid = v; bus.mnem = r.mnem; bus.rs = r.rs; bus.rt = r.rt; bus.rd = r.rd;
        bus.shamt = r.shamt; bus.funct = r.funct; bus.imm = r.imm; bus.target = r.target;
    endtask

    task automatic wdrive(input req_t r, input logic v);
        wbus.in_valid = v; wbus.mnem = r.mnem; wbus.rs = r.rs; wbus.rt = r.rt; wbus.rd = r.rd;
        wbus.shamt = r.shamt; wbus.funct = r.funct; wbus.imm = r.imm; wbus.target = r.target;
    endtask

    task automatic check_all();
        chk("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
        chk("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
        chk("out_instr", bus.out_instr, (mq.size() > 0) ? mq[0] : 32'h0);
        chk("out_addr", bus.out_addr, m_addr);
        chk("err", 32'(bus.err), 32'(m_err));
    endtask

    // One clock: model evaluates the inputs currently driven, then DUT is compared after the edge.
    task automatic step();
        req_t r;
        bit flush, acc, pop;
        r = mk(bus.mnem, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct, bus.imm, bus.target);
        flush = reset || clear;
        acc = bus.in_valid && (mq.size() < DEPTH);
        pop = (mq.size() > 0) && bus.out_ready;
        @(posedge clk);
        #1;
        if (flush) begin
            mq.delete();
            m_addr = BASE;
            m_err = 1'b0;
        end else begin
            if (pop) begin
                void'(mq.pop_front());
                m_addr = m_addr + 32'd4;
            end
            if (acc && m_legal(r.mnem)) mq.push_back(m_enc(r));
            m_err = acc && !m_legal(r.mnem);
        end
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(mk(ADDI, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        step();
        reset = 1'b0;
    endtask

    vec_t vecs[11];
    logic [31:0] saved_addr;

    initial begin
        reset = 1'b1; clear = 1'b0; clear_w = 1'b0;
        bus.out_ready = 1'b0; wbus.out_ready = 1'b1;
        drive(mk(ADDI, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        wdrive(mk(ADDI, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        m_addr = BASE; m_err = 1'b0;
        step();
        step();
        chk("rst_instr", bus.out_instr, 32'h0);
        chk("wrap_rst_addr", wbus.out_addr, WBASE);
        reset = 1'b0;

        vecs[0]  = '{mk(ADDI, 1, 2, 0, 0, 0, 16'h0005, 0), 32'h2022_0005, 1'b0};
        vecs[1]  = '{mk(RTYPE, 1, 2, 3, 0, 6'b100000, 0, 0), 32'h0022_1820, 1'b0};
        vecs[2]  = '{mk(JR, 31, 0, 0, 0, 0, 0, 0), 32'h03E0_0008, 1'b0};
        vecs[3]  = '{mk(LW, 29, 8, 0, 0, 0, 16'h0010, 0), 32'h8FA8_0010, 1'b0};
        vecs[4]  = '{mk(SW, 29, 9, 0, 0, 0, 16'hFFFC, 0), 32'hAFA9_FFFC, 1'b0};
        vecs[5]  = '{mk(BEQ, 4, 5, 0, 0, 0, 16'h0003, 0), 32'h1085_0003, 1'b0};
        vecs[6]  = '{mk(ORI, 0, 1, 0, 0, 0, 16'hABCD, 0), 32'h3401_ABCD, 1'b0};
        vecs[7]  = '{mk(J, 0, 0, 0, 0, 0, 0, 26'h010_0000), 32'h0810_0000, 1'b0};
        vecs[8]  = '{mk(LUI, 0, 8, 0, 0, 0, 16'h1234, 0), 32'h3C08_1234, !EXT};
        vecs[9]  = '{mk(BNE, 1, 2, 0, 0, 0, 16'h0008, 0), 32'h1422_0008, !EXT};
        vecs[10] = '{mk(mnem_t'(5'd25), 3, 3, 3, 3, 3, 3, 3), 32'h0, 1'b1};

        bus.out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            saved_addr = bus.out_addr;
            drive(vecs[i].req, 1'b1);
            step();
            chk("vec_instr", bus.out_instr, vecs[i].exp_err ? 32'h0 : vecs[i].exp_instr);
            chk("vec_err", 32'(bus.err), 32'(vecs[i].exp_err));
            if (i == 0) chk("vec_first_addr", bus.out_addr, BASE);
            drive(vecs[i].req, 1'b0);
            step();
            chk("vec_err_clr", 32'(bus.err), 32'h0);
            chk("vec_addr_step", bus.out_addr, saved_addr + (vecs[i].exp_err ? 32'd0 : 32'd4));
        end

        // Back-to-back RTYPE then JR from a fresh address counter.
        do_reset();
        drive(vecs[1].req, 1'b1);
        step();
        chk("seq_rtype", bus.out_instr, 32'h0022_1820);
        chk("seq_rtype_addr", bus.out_addr, 32'h0);
        drive(vecs[2].req, 1'b1);
        step();
        chk("seq_jr", bus.out_instr, 32'h03E0_0008);
        chk("seq_jr_addr", bus.out_addr, 32'h4);
        drive(vecs[2].req, 1'b0);
        step();

        // Fill to full with backpressure, blocked fifth request, then drain.
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(mk(ADDI, 1, 2, 0, 0, 0, i + 1, 0), 1'b1);
            step();
        end
        chk("full_in_ready", 32'(bus.in_ready), 32'h0);
        drive(mk(ADDI, 1, 2, 0, 0, 0, 5, 0), 1'b1);
        step();
        chk("full_blocked", 32'(bus.in_ready), 32'h0);
        chk("full_head", bus.out_instr, 32'h2022_0001);
        drive(mk(ADDI, 1, 2, 0, 0, 0, 5, 0), 1'b0);
        bus.out_ready = 1'b1;
        step();
        chk("ready_after_pop", 32'(bus.in_ready), 32'h1);
        for (int i = 0; i < 3; i++) step();
        chk("drained", 32'(bus.out_valid), 32'h0);

        // Illegal-in-default-build request: address must not move.
        saved_addr = bus.out_addr;
        drive(vecs[8].req, 1'b1);
        step();
        drive(vecs[8].req, 1'b0);
        step();
        step();
        chk("lui_addr", bus.out_addr, saved_addr + (EXT ? 32'd4 : 32'd0));

        // Clear with three words buffered and a request present.
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(mk(ORI, 2, 3, 0, 0, 0, i, 0), 1'b1);
            step();
        end
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        drive(mk(ORI, 2, 3, 0, 0, 0, 0, 0), 1'b0);
        chk("clr_empty", 32'(bus.out_valid), 32'h0);
        chk("clr_addr", bus.out_addr, BASE);
        step();
        chk("clr_discard", 32'(bus.out_valid), 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(mk(LW, 4, 5, 0, 0, 0, i, 0), 1'b1);
            step();
        end
        reset = 1'b1;
        clear = 1'b1;
        step();
        reset = 1'b0;
        clear = 1'b0;
        drive(mk(LW, 4, 5, 0, 0, 0, 0, 0), 1'b0);
        step();
        chk("rst_discard", 32'(bus.out_valid), 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);

        // Address wrap on the BASE_ADDR=FFFF_FFFC instance.
        wdrive(vecs[0].req, 1'b1);
        step();
        chk("wrap_addr0", wbus.out_addr, 32'hFFFF_FFFC);
        chk("wrap_valid0", 32'(wbus.out_valid), 32'h1);
        wdrive(vecs[3].req, 1'b1);
        step();
        chk("wrap_addr1", wbus.out_addr, 32'h0000_0000);
        chk("wrap_instr1", wbus.out_instr, 32'h8FA8_0010);
        wdrive(vecs[3].req, 1'b0);
        step();
        chk("wrap_drained", 32'(wbus.out_valid), 32'h0);

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            drive(rand_req(), $urandom_range(0, 9) < 7);
            bus.out_ready = $urandom_range(0, 9) < 5;
            clear = $urandom_range(0, 39) == 0;
            reset = $urandom_range(0, 99) == 0;
            step();
        end
        reset = 1'b0;
        clear = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DEPTH, default 4, sets the output FIFO entry count; a power of two, at least 2.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, sets the byte address of the first emitted word.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 clear  input  1  synchronous flush of the FIFO and the address counter.
REQ-006 in_valid  input  1  request present; in_ready  output  1  request accepted when both are high.
REQ-007 mnem  input  5  mnemonic code of type mnem_t.
REQ-008 rs, rt, rd, shamt  input  5 each; funct  input  6; imm  input  16; target  input  26  instruction fields.
REQ-009 out_valid  output  1; out_ready  input  1  word transferred when both are high.
REQ-010 out_instr  output  32  encoded word; out_addr  output  32  byte address of out_instr.
REQ-011 err  output  1  one-cycle pulse when an illegal request is rejected.

Function
REQ-012 On handshake, encoding SHALL be R-type {6'b0,rs,rt,rd,shamt,funct}, JR {6'b0,rs,15'b0,6'b001000}, J/JAL {op,target}, all others {op,rs,rt,imm}.
REQ-013 Opcodes: LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000, ORI 001101, J 000010, LH 100001, LB 100000, LBU 100100, ANDI 001100, JAL 000011, LUI 001111, XORI 001110, BLEZ 000110, SLTI 001010, BGTZ 000111.
REQ-014 The encoded word SHALL be written into the FIFO on the accept edge; out_valid rises in the cycle after the accept when the FIFO was empty (latency 1).
REQ-015 in_ready SHALL equal !full; a simultaneous pop does not raise in_ready in the same cycle.
REQ-016 A simultaneous push and pop on a non-full, non-empty FIFO SHALL keep the occupancy unchanged.
REQ-017 out_instr SHALL hold stable while out_valid is high and out_ready is low.
REQ-018 out_addr SHALL start at BASE_ADDR and add 4 on each output handshake, wrapping modulo 2^32.
REQ-019 An unsupported mnem SHALL still be accepted when in_ready is high, SHALL NOT be pushed, and SHALL pulse err high for exactly the next cycle.
REQ-020 When clear is high, the FIFO SHALL empty and out_addr SHALL return to BASE_ADDR on that edge; any push or pop in that cycle is discarded.
REQ-021 When the FIFO is full, the pointers SHALL wrap modulo DEPTH with a separate full/empty distinction (extra pointer bit).

Reset
REQ-022 With reset high: FIFO empty, out_valid=0, in_ready=1 from the next cycle, out_addr=BASE_ADDR, err=0, out_instr=32'h0.
REQ-023 A reset mid-stream SHALL drop all buffered words and any request presented in that cycle; reset takes priority over clear.

Configuration
REQ-024 Macro MIPS_ENC_EXT_EN SHALL be the only compile-time option.
REQ-025 With the macro defined, all mnemonics in REQ-013 plus RTYPE and JR SHALL be legal.
REQ-026 With the macro undefined, only RTYPE, JR, LW, SW, BEQ, ADDI, ORI and J SHALL be legal, and all other codes follow REQ-019.

Structure
REQ-027 Package mips_pkg SHALL hold the enum mnem_t (RTYPE, JR, LW, SW, BEQ, BNE, ADDI, ORI, J, LH, LB, LBU, ANDI, JAL, LUI, XORI, BLEZ, SLTI, BGTZ), the opcode constants and the JR funct constant.
REQ-028 The encode logic SHALL be combinational inside instr_encoder.
REQ-029 Buffering SHALL be one sub-module, instr_fifo, parameterised by width 32 and DEPTH.

Verification
REQ-030 ADDI rs=1 rt=2 imm=16'h0005 with out_ready=1 -> out_valid rises the next cycle with out_instr=32'h2022_0005 and out_addr=32'h0.
REQ-031 RTYPE rs=1 rt=2 rd=3 shamt=0 funct=100000, then JR rs=31 -> output words 32'h0022_1820 then 32'h03E0_0008 at addresses 0 and 4.
REQ-032 out_ready=0 with 5 pushes at DEPTH=4 -> in_ready goes low after the 4th push; out_ready=1 then drains 4 words in order, and in_ready returns 1 cycle after the first pop.
REQ-033 Macro undefined, mnem=LUI -> no push, err=1 for one cycle, and out_addr is unchanged; with the macro defined, LUI rt=8 imm=16'h1234 -> 32'h3C08_1234.
REQ-034 Three words buffered, then clear=1 together with in_valid=1 -> FIFO empty, out_addr=BASE_ADDR, and the request is discarded; the same with reset=1 gives the REQ-022 state.
REQ-035 BASE_ADDR=32'hFFFF_FFFC with 2 words streamed -> out_addr values FFFF_FFFC then 0000_0000.
